// File: rtl/dct_accumulator.sv
// dct_accumulator
//   Pipelined multi-operand adder/subtractor. Sums a block of COUNT samples
//   into one full-precision two's complement result; each sample may be
//   added or subtracted individually. An output holding register lets the
//   next block accumulate while a result waits for the downstream consumer.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   clear         synchronous abort of the partial block (result reg untouched)
//   in_valid      sample present
//   in_ready      block can accept the sample this cycle
//   in_data       sample (WIDTH bits, signed or unsigned per SIGNED)
//   in_sub        1 = subtract this sample, 0 = add it
//   out_valid     result held in the output register
//   out_ready     downstream accepts the result
//   out_data      block sum (OUT_W bits, two's complement)
//   sample_idx    index of the next sample to be accepted within the block
module dct_accumulator #(
  parameter  int WIDTH  = 8,
  parameter  int COUNT  = 8,
  parameter  int SIGNED = 1,
  localparam int IDX_W  = $clog2(COUNT),
  localparam int OUT_W  = WIDTH + $clog2(COUNT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0] sample_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] operand;
  logic [OUT_W-1:0] sum;
  logic             is_last;
  logic             accept;

  always_comb begin
    ext = '0;
    if (SIGNED != 0) begin
      ext = {{(OUT_W - WIDTH){in_data[WIDTH-1]}}, in_data};
    end else begin
      ext = {{(OUT_W - WIDTH){1'b0}}, in_data};
    end
    operand = in_sub ? ('0 - ext) : ext;
    sum     = acc + operand;
  end

  assign is_last = (sample_idx == LAST_IDX);

  // Only the final sample of a block waits on the output register; it may
  // still enter in the same cycle the pending result is consumed.
  assign in_ready = !rst && !clear && !(is_last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      sample_idx <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      // A final-sample load below overrides this clear in the same cycle.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (clear) begin
        acc        <= '0;
        sample_idx <= '0;
      end else if (accept) begin
        if (is_last) begin
          out_data   <= sum;
          out_valid  <= 1'b1;
          acc        <= '0;
          sample_idx <= '0;
        end else begin
          acc        <= sum;
          sample_idx <= sample_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_accumulator.sv
// Testbench for dct_accumulator: one signed and one unsigned instance
// (WIDTH=8, COUNT=8). Table-driven blocks plus hand-written sequences for
// backpressure, clear and mid-block reset; results go through a scoreboard.
module tb_dct_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [7:0]  in_data;
  logic        in_sub;
  logic        out_ready;
  logic        v_s, v_u;
  logic        rdy_s, rdy_u;
  logic        ov_s, ov_u;
  logic [11:0] od_s, od_u;
  logic [2:0]  idx_s, idx_u;

  int checks = 0;
  int fails  = 0;
  int stalls = 0;
  int m_acc[2];
  int m_idx[2];
  int q_s[$];
  int q_u[$];
  bit use_tbl = 1'b0;
  int tbl_exp = 0;

  typedef struct {
    bit          uns;
    logic [63:0] d;    // sample i in bits [8*i +: 8]
    logic [7:0]  sub;  // bit i = subtract sample i
    int          exp;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  dct_accumulator #(.WIDTH(8), .COUNT(8), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(v_s), .in_ready(rdy_s),
    .in_data(in_data), .in_sub(in_sub), .out_valid(ov_s), .out_ready(out_ready),
    .out_data(od_s), .sample_idx(idx_s)
  );

  dct_accumulator #(.WIDTH(8), .COUNT(8), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(v_u), .in_ready(rdy_u),
    .in_data(in_data), .in_sub(in_sub), .out_valid(ov_u), .out_ready(out_ready),
    .out_data(od_u), .sample_idx(idx_u)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a result is popped when it is handshaken out.
  always @(negedge clk) begin
    if (!rst) begin
      if (ov_s && out_ready) begin
        if (q_s.size() == 0) begin
          checks++; fails++;
          $display("FAIL sb_s_unexpected: got %0d, expected no result", int'($signed(od_s)));
        end else begin
          check("sb_s_result", int'($signed(od_s)), q_s.pop_front());
        end
      end
      if (ov_u && out_ready) begin
        if (q_u.size() == 0) begin
          checks++; fails++;
          $display("FAIL sb_u_unexpected: got %0d, expected no result", int'($signed(od_u)));
        end else begin
          check("sb_u_result", int'($signed(od_u)), q_u.pop_front());
        end
      end
    end
  end

  // Offer one sample to the chosen instance and wait (bounded) for acceptance.
  task automatic send(input bit u, input logic [7:0] d, input bit sub);
    int op;
    int r;
    bit ok;
    bit last;
    ok = 1'b0;
    last = 1'b0;
    in_data = d;
    in_sub  = sub;
    v_s = !u;
    v_u = u;
    for (int w = 0; w < 40; w++) begin
      @(negedge clk);
      if (u ? rdy_u : rdy_s) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) begin
      checks++; fails++;
      $display("FAIL ready_timeout: got in_ready=0 for 40 cycles, expected 1");
    end else begin
      check(u ? "idx_u" : "idx_s", int'(u ? idx_u : idx_s), m_idx[u]);
      op = u ? int'(d) : int'($signed(d));
      if (sub) op = -op;
      if (m_idx[u] == 7) begin
        r = use_tbl ? tbl_exp : m_acc[u] + op;
        if (u) q_u.push_back(r); else q_s.push_back(r);
        m_acc[u] = 0;
        m_idx[u] = 0;
        last = 1'b1;
      end else begin
        m_acc[u] += op;
        m_idx[u]++;
      end
    end
    @(posedge clk); #1;
    v_s = 1'b0;
    v_u = 1'b0;
    if (last) check("latency_out_valid", int'(u ? ov_u : ov_s), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, {8{8'd127}}, 8'h00, 1016};
    tbl[1] = '{1'b0, {8{8'h80}},  8'h00, -1024};
    tbl[2] = '{1'b1, {8{8'd255}}, 8'hFF, -2040};
    tbl[3] = '{1'b1, {8{8'd10}},  8'hAA, 0};
    tbl[4] = '{1'b1, {8{8'd0}},   8'h00, 0};
    tbl[5] = '{1'b0, {8{8'h80}},  8'hFF, 1024};
    tbl[6] = '{1'b1, {8{8'd255}}, 8'h00, 2040};
    tbl[7] = '{1'b0, {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 8'h00, 36};
    tbl[8] = '{1'b0, {8'd16, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd9}, 8'h00, 100};
    m_acc = '{0, 0};
    m_idx = '{0, 0};

    rst = 1'b1; clear = 1'b0; in_data = '0; in_sub = 1'b0;
    out_ready = 1'b1; v_s = 1'b0; v_u = 1'b0;

    // Reset state
    @(negedge clk);
    check("ready_in_reset", int'(rdy_s), 0);
    idle(2);
    rst = 1'b0;
    check("reset_out_valid", int'(ov_s), 0);
    check("reset_out_data", int'(od_s), 0);
    check("reset_idx", int'(idx_s), 0);
    check("reset_out_valid_u", int'(ov_u), 0);
    @(negedge clk);
    check("ready_after_reset", int'(rdy_s), 1);
    @(posedge clk); #1;

    // Table blocks, out_ready=1, back-to-back (rows 7 and 8 give 36, 100)
    use_tbl = 1'b1;
    stalls = 0;
    for (int r = 0; r < 9; r++) begin
      tbl_exp = tbl[r].exp;
      for (int i = 0; i < 8; i++) begin
        send(tbl[r].uns, tbl[r].d[8*i +: 8], tbl[r].sub[i]);
      end
    end
    check("table_stalls", stalls, 0);
    use_tbl = 1'b0;
    idle(3);

    // Backpressure: hold 36, second block's final sample waits
    for (int i = 1; i <= 8; i++) send(1'b0, 8'(i), 1'b0);
    out_ready = 1'b0;
    stalls = 0;
    for (int i = 9; i <= 15; i++) send(1'b0, 8'(i), 1'b0);
    check("bp_nonfinal_stalls", stalls, 0);
    in_data = 8'd16; in_sub = 1'b0; v_s = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("bp_ready_low", int'(rdy_s), 0);
      check("bp_idx", int'(idx_s), 7);
      check("bp_hold_data", int'($signed(od_s)), 36);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    stalls = 0;
    send(1'b0, 8'd16, 1'b0);
    check("bp_final_stalls", stalls, 0);
    check("bp_new_data", int'($signed(od_s)), 100);
    idle(3);

    // clear with a pending result
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(1'b0, 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) send(1'b0, 8'd50, 1'b0);
    in_data = 8'd50; v_s = 1'b1; clear = 1'b1;
    @(negedge clk);
    check("clear_ready_low", int'(rdy_s), 0);
    @(posedge clk); #1;
    clear = 1'b0; v_s = 1'b0;
    m_acc[0] = 0; m_idx[0] = 0;
    check("clear_idx", int'(idx_s), 0);
    check("clear_keeps_valid", int'(ov_s), 1);
    check("clear_keeps_data", int'($signed(od_s)), 36);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(1'b0, 8'd1, 1'b0);
    idle(3);

    // Reset mid-block with a pending result
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b0, 8'd2, 1'b0);
    for (int i = 0; i < 3; i++) send(1'b0, 8'd7, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready_low", int'(rdy_s), 0);
    q_s.delete(); q_u.delete();
    m_acc = '{0, 0}; m_idx = '{0, 0};
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_out_valid", int'(ov_s), 0);
    check("rst_out_data", int'(od_s), 0);
    check("rst_idx", int'(idx_s), 0);
    @(negedge clk);
    check("rst_ready_after", int'(rdy_s), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(1'b0, 8'hFB, 1'b0);  // -5 x 8 = -40
    idle(4);

    check("sb_s_drained", q_s.size(), 0);
    check("sb_u_drained", q_u.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
